// File: rtl/mio_amba_apb_bridge.sv
// mio_amba_apb_bridge: registered APB-to-APB bridge with one-hot select check and downstream timeout.
// Captures an upstream transfer, replays it downstream as SETUP/ACCESS and returns a registered response.
module mio_amba_apb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLV        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] s_paddr,
    input  logic [NUM_SLV-1:0]    s_psel,
    input  logic                  s_penable,
    input  logic                  s_pwrite,
    input  logic [DATA_WIDTH-1:0] s_pwdata,
    output logic                  s_pready,
    output logic [DATA_WIDTH-1:0] s_prdata,
    output logic                  s_pslverr,
    output logic [ADDR_WIDTH-1:0] m_paddr,
    output logic [NUM_SLV-1:0]    m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [DATA_WIDTH-1:0] m_pwdata,
    input  logic                  m_pready,
    input  logic [DATA_WIDTH-1:0] m_prdata,
    input  logic                  m_pslverr,
    output logic                  busy,
    output logic                  timeout_pulse
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] m_paddr_q, m_paddr_d;
    logic [NUM_SLV-1:0]    m_psel_q, m_psel_d;
    logic                  m_penable_q, m_penable_d;
    logic                  m_pwrite_q, m_pwrite_d;
    logic [DATA_WIDTH-1:0] m_pwdata_q, m_pwdata_d;
    logic                  s_pready_q, s_pready_d;
    logic [DATA_WIDTH-1:0] s_prdata_q, s_prdata_d;
    logic                  s_pslverr_q, s_pslverr_d;
    logic                  busy_q, busy_d;
    logic                  timeout_pulse_q, timeout_pulse_d;
    logic                  start, one_hot, expire;

    assign start   = |s_psel && s_penable;
    assign one_hot = (s_psel & (s_psel - NUM_SLV'(1))) == '0;
    assign expire  = (TIMEOUT_CYCLES > 0) && cnt_q == CNT_LAST;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        m_paddr_d       = m_paddr_q;
        m_psel_d        = m_psel_q;
        m_penable_d     = m_penable_q;
        m_pwrite_d      = m_pwrite_q;
        m_pwdata_d      = m_pwdata_q;
        s_pready_d      = 1'b0;
        s_prdata_d      = s_prdata_q;
        s_pslverr_d     = s_pslverr_q;
        timeout_pulse_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                m_paddr_d  = s_paddr;
                m_pwrite_d = s_pwrite;
                m_pwdata_d = s_pwdata;
                if (one_hot) begin
                    state_d  = SETUP;
                    m_psel_d = s_psel;
                end else begin
                    // Illegal multi-bit select: answer with an error, never touch the downstream bus
                    state_d     = RESP;
                    s_pready_d  = 1'b1;
                    s_pslverr_d = 1'b1;
                    s_prdata_d  = '0;
                end
            end
            SETUP: begin
                state_d     = ACCESS;
                m_penable_d = 1'b1;
            end
            ACCESS: if (m_pready || expire) begin
                // A completion in the last allowed cycle takes precedence over the abort
                state_d         = RESP;
                m_psel_d        = '0;
                m_penable_d     = 1'b0;
                s_pready_d      = 1'b1;
                s_pslverr_d     = m_pready ? m_pslverr : 1'b1;
                s_prdata_d      = (m_pready && !m_pwrite_q) ? m_prdata : '0;
                timeout_pulse_d = !m_pready;
            end else begin
                cnt_d = (TIMEOUT_CYCLES > 0) ? cnt_q + CW'(1) : cnt_q;
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            m_paddr_q       <= '0;
            m_psel_q        <= '0;
            m_penable_q     <= 1'b0;
            m_pwrite_q      <= 1'b0;
            m_pwdata_q      <= '0;
            s_pready_q      <= 1'b0;
            s_prdata_q      <= '0;
            s_pslverr_q     <= 1'b0;
            busy_q          <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            m_paddr_q       <= m_paddr_d;
            m_psel_q        <= m_psel_d;
            m_penable_q     <= m_penable_d;
            m_pwrite_q      <= m_pwrite_d;
            m_pwdata_q      <= m_pwdata_d;
            s_pready_q      <= s_pready_d;
            s_prdata_q      <= s_prdata_d;
            s_pslverr_q     <= s_pslverr_d;
            busy_q          <= busy_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign s_pready      = s_pready_q;
    assign s_prdata      = s_prdata_q;
    assign s_pslverr     = s_pslverr_q;
    assign m_paddr       = m_paddr_q;
    assign m_psel        = m_psel_q;
    assign m_penable     = m_penable_q;
    assign m_pwrite      = m_pwrite_q;
    assign m_pwdata      = m_pwdata_q;
    assign busy          = busy_q;
    assign timeout_pulse = timeout_pulse_q;
endmodule

// File: tb/tb_mio_amba_apb_bridge.sv
// tb_mio_amba_apb_bridge: directed and randomized transfers against a latency/response reference model.
module tb_mio_amba_apb_bridge;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] s_paddr = '0;
    logic [3:0]  s_psel = '0;
    logic        s_penable = 1'b0;
    logic        s_pwrite = 1'b0;
    logic [31:0] s_pwdata = '0;
    logic        s_pready;
    logic [31:0] s_prdata;
    logic        s_pslverr;
    logic [31:0] m_paddr;
    logic [3:0]  m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [31:0] m_pwdata;
    logic        m_pready = 1'b0;
    logic [31:0] m_prdata = '0;
    logic        m_pslverr = 1'b0;
    logic        busy;
    logic        timeout_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mio_amba_apb_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLV(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_pwdata(s_pwdata), .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_pwdata(m_pwdata), .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
        .busy(busy), .timeout_pulse(timeout_pulse)
    );

    // Reference model: cycle (relative to the upstream access cycle) at which each event is due
    function automatic void model(input logic [3:0] sel, input logic wr, input int waits,
                                  input logic [31:0] rd, input logic se,
                                  output int lat, output int setup_c, output logic [31:0] erd,
                                  output logic eerr, output int eto);
        if ($countones(sel) != 1) begin
            lat = 1; setup_c = -1; erd = '0; eerr = 1'b1; eto = 0;
        end else if (TO > 0 && waits >= TO) begin
            lat = TO + 2; setup_c = 1; erd = '0; eerr = 1'b1; eto = 1;
        end else begin
            lat = 3 + waits; setup_c = 1; erd = wr ? 32'h0 : rd; eerr = se; eto = 0;
        end
    endfunction

    // Drives one upstream transfer and plays a downstream completer that inserts `waits` wait states
    task automatic xfer(input logic [31:0] a, input logic [3:0] sel, input logic wr,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd, input logic se,
                        output int lat, output int setup_c, output int acc_c,
                        output logic [31:0] got_rd, output logic got_err,
                        output int to_cnt, output int to_c, output logic busy_after, output int perr);
        int n;
        lat = -1; setup_c = -1; acc_c = -1; to_cnt = 0; to_c = -1; perr = 0; n = 0;
        got_rd = 'x; got_err = 1'bx;
        @(negedge clk);
        s_paddr = a; s_psel = sel; s_penable = 1'b1; s_pwrite = wr; s_pwdata = wd;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            if (timeout_pulse) begin to_cnt++; to_c = k; end
            if (m_psel != 0 && !m_penable && setup_c < 0) setup_c = k;
            if (m_penable && acc_c < 0) acc_c = k;
            if (m_psel != 0 && (m_psel !== sel || m_paddr !== a || m_pwrite !== wr || (wr && m_pwdata !== wd))) perr++;
            if (m_penable && m_psel == 0) perr++;
            if (!busy) perr++;
            if (s_pready) begin
                lat = k; got_rd = s_prdata; got_err = s_pslverr;
                s_psel = '0; s_penable = 1'b0;
            end
            m_pready = 1'b0;
            if (m_penable) begin
                n++;
                m_pready = (n == waits + 1);
                m_prdata = m_pready ? rd : $urandom;
                m_pslverr = m_pready ? se : 1'($urandom);
            end
        end
        s_psel = '0; s_penable = 1'b0; m_pready = 1'b0;
        @(negedge clk);
        busy_after = busy;
        if (timeout_pulse) to_cnt++;
        if (m_psel != 0 || m_penable) perr++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({s_pready, s_prdata, s_pslverr, m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, busy, timeout_pulse} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got psel=%b pen=%b busy=%b pready=%b want all zero", m_psel, m_penable, busy, s_pready);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_write;
        int lat, su, ac, tc, tcy, pe; logic [31:0] rd; logic er, ba;
        xfer(32'h100, 4'b0010, 1'b1, 32'hA5A5_0001, 0, 32'h1234_5678, 1'b0, lat, su, ac, rd, er, tc, tcy, ba, pe);
        n_cmp++; if (su !== 1) begin n_bad++; $display("FAIL write_setup: got %0d want 1", su); end
        n_cmp++; if (ac !== 2) begin n_bad++; $display("FAIL write_access: got %0d want 2", ac); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL write_latency: got %0d want 3", lat); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL write_err: got %b want 0", er); end
        n_cmp++; if (pe !== 0) begin n_bad++; $display("FAIL write_protocol: got %0d want 0", pe); end
    endtask

    task automatic test_read_wait;
        int lat, su, ac, tc, tcy, pe; logic [31:0] rd; logic er, ba;
        xfer(32'h204, 4'b0001, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, lat, su, ac, rd, er, tc, tcy, ba, pe);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL read_latency: got %0d want 6", lat); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL read_data: got %h want deadbeef", rd); end
        n_cmp++; if (pe !== 0) begin n_bad++; $display("FAIL read_protocol: got %0d want 0", pe); end
    endtask

    task automatic test_timeout;
        int lat, su, ac, tc, tcy, pe; logic [31:0] rd; logic er, ba;
        xfer(32'h300, 4'b0100, 1'b0, 32'h0, 1000, 32'hFFFF_FFFF, 1'b0, lat, su, ac, rd, er, tc, tcy, ba, pe);
        n_cmp++; if (lat !== TO + 2) begin n_bad++; $display("FAIL timeout_latency: got %0d want %0d", lat, TO + 2); end
        n_cmp++; if (tc !== 1 || tcy !== TO + 2) begin n_bad++; $display("FAIL timeout_pulse: got count %0d at %0d want 1 at %0d", tc, tcy, TO + 2); end
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL timeout_resp: got err=%b data=%h want err=1 data=0", er, rd); end
        n_cmp++; if (ba !== 1'b0) begin n_bad++; $display("FAIL timeout_busy_after: got %b want 0", ba); end
    endtask

    task automatic test_bad_sel;
        int lat, su, ac, tc, tcy, pe; logic [31:0] rd; logic er, ba;
        xfer(32'h400, 4'b0110, 1'b1, 32'h5555_AAAA, 0, 32'h0, 1'b0, lat, su, ac, rd, er, tc, tcy, ba, pe);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL badsel_latency: got %0d want 1", lat); end
        n_cmp++; if (su !== -1 || ac !== -1 || pe !== 0) begin n_bad++; $display("FAIL badsel_downstream: got setup=%0d access=%0d perr=%0d want none", su, ac, pe); end
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL badsel_resp: got err=%b data=%h want err=1 data=0", er, rd); end
    endtask

    task automatic test_limit;
        int lat, su, ac, tc, tcy, pe; logic [31:0] rd; logic er, ba;
        xfer(32'h500, 4'b1000, 1'b0, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b1, lat, su, ac, rd, er, tc, tcy, ba, pe);
        n_cmp++; if (lat !== TO + 2) begin n_bad++; $display("FAIL limit_latency: got %0d want %0d", lat, TO + 2); end
        n_cmp++; if (tc !== 0) begin n_bad++; $display("FAIL limit_no_timeout: got %0d pulses want 0", tc); end
        n_cmp++; if (er !== 1'b1 || rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL limit_resp: got err=%b data=%h want err=1 data=cafef00d", er, rd); end
    endtask

    task automatic test_reset_mid;
        int lat, su, ac, tc, tcy, pe; logic [31:0] rd; logic er, ba;
        bit seen;
        seen = 0;
        @(negedge clk);
        s_paddr = 32'h600; s_psel = 4'b0001; s_penable = 1'b1; s_pwrite = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = m_penable;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_access: got no ACCESS within 10 cycles want ACCESS"); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (m_psel !== 4'b0 || m_penable !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_async: got psel=%b pen=%b busy=%b want 0", m_psel, m_penable, busy); end
        s_psel = '0; s_penable = 1'b0;
        @(negedge clk);
        n_cmp++; if (s_pready !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_resp: got %b want 0", s_pready); end
        reset_n = 1'b1;
        xfer(32'h604, 4'b0001, 1'b0, 32'h0, 1, 32'h0BAD_CAFE, 1'b0, lat, su, ac, rd, er, tc, tcy, ba, pe);
        n_cmp++; if (lat !== 4 || rd !== 32'h0BAD_CAFE || er !== 1'b0) begin n_bad++; $display("FAIL rstmid_next: got lat=%0d data=%h err=%b want lat=4 data=0badcafe err=0", lat, rd, er); end
    endtask

    task automatic test_random;
        int lat, su, ac, tc, tcy, pe, waits, elat, esu, eto;
        logic [31:0] rd, a, wd, drd, erd; logic er, ba, wr, se, eerr; logic [3:0] sel;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; wd = $urandom; drd = $urandom; wr = 1'($urandom); se = 1'($urandom);
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
            waits = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 5);
            model(sel, wr, waits, drd, se, elat, esu, erd, eerr, eto);
            xfer(a, sel, wr, wd, waits, drd, se, lat, su, ac, rd, er, tc, tcy, ba, pe);
            n_cmp++;
            if (lat !== elat || su !== esu || rd !== erd || er !== eerr || tc !== eto || ba !== 1'b0 || pe !== 0) begin
                n_bad++;
                $display("FAIL random_%0d: got lat=%0d setup=%0d data=%h err=%b to=%0d busy=%b perr=%0d want lat=%0d setup=%0d data=%h err=%b to=%0d busy=0 perr=0",
                         i, lat, su, rd, er, tc, ba, pe, elat, esu, erd, eerr, eto);
            end
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read_wait;
        test_timeout;
        test_bad_sel;
        test_limit;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mio_amba_apb_bridge.md
Name: mio_amba_apb_bridge

Overview:
Registered APB-to-APB bridge that replaces a pure wire pass-through DUT in the AMBA self-test bench. It captures an upstream transfer, re-launches it downstream as a full SETUP/ACCESS sequence to one of NUM_SLV completers, and returns the registered response. It also adds a parametrised downstream timeout and rejects illegal multi-bit selects.

Parameters:
ADDR_WIDTH, 32, width of paddr on both sides
DATA_WIDTH, 32, width of pwdata/prdata (8, 16 or 32)
NUM_SLV, 4, number of downstream completers (psel vector width), 1..16
TIMEOUT_CYCLES, 16, max downstream ACCESS cycles before abort; 0 disables timeout

Ports:
clk  in  1  single clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
s_paddr  in  ADDR_WIDTH  upstream address
s_psel  in  NUM_SLV  upstream one-hot select
s_penable  in  1  upstream access phase
s_pwrite  in  1  upstream direction, 1=write
s_pwdata  in  DATA_WIDTH  upstream write data
s_pready  out  1  upstream completion, one-cycle pulse
s_prdata  out  DATA_WIDTH  upstream read data, registered
s_pslverr  out  1  upstream error, valid with s_pready
m_paddr  out  ADDR_WIDTH  downstream address, registered
m_psel  out  NUM_SLV  downstream select, registered
m_penable  out  1  downstream access phase
m_pwrite  out  1  downstream direction
m_pwdata  out  DATA_WIDTH  downstream write data
m_pready  in  1  downstream completion
m_prdata  in  DATA_WIDTH  downstream read data
m_pslverr  in  1  downstream error
busy  out  1  high in any state other than IDLE
timeout_pulse  out  1  one-cycle pulse when a downstream timeout aborts a transfer

Behaviour:
- Reset (async assert, sync deassert to clk): state IDLE, every output 0, timeout counter 0. Assertion mid-transfer drops m_psel/m_penable at once; the transfer is lost with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: s_pready=0. On s_psel!=0 && s_penable=1, register paddr, pwrite, pwdata and psel.
  - If s_psel is one-hot, go to SETUP.
  - Otherwise go to RESP with err=1 and rdata=0. No downstream cycle occurs.
- SETUP (1 cycle): m_psel=captured psel, m_penable=0. Go to ACCESS.
- ACCESS: m_penable=1, m_psel held, counter increments each cycle.
  - On m_pready=1: capture m_prdata (0 for writes) and m_pslverr, go to RESP.
  - Else, if TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1: err=1, rdata=0, timeout_pulse=1 next cycle, go to RESP.
  - m_pready and timeout in the same cycle: m_pready wins, no timeout.
- RESP (1 cycle): m_psel=0, m_penable=0, s_pready=1, s_prdata/s_pslverr registered values. Go to IDLE. Counter cleared.
- s_prdata and s_pslverr hold their values outside RESP. They are only defined while s_pready=1.
- Latency: upstream access at cycle T gives m SETUP at T+1 and m ACCESS at T+2. With zero downstream wait states, s_pready=1 at T+3. Each downstream wait state adds 1 cycle.
- Upstream signal changes after capture are ignored until RESP (no re-capture). A back-to-back upstream transfer is captured only from IDLE, i.e. at T+4 or later.
- Counter width is clog2(TIMEOUT_CYCLES+1). It never wraps; it saturates at abort.
- m_paddr, m_pwrite and m_pwdata hold their last captured values when idle.

Test Plan:
- Write 0xA5A5_0001 to 0x100, psel=4'b0010, m_pready=1 -> m_psel=0010 at T+1 with m_penable=0, then m_penable=1 at T+2, s_pready=1 at T+3 with s_pslverr=0.
- Read 0x204, psel=4'b0001, m_pready low for 3 cycles, m_prdata=0xDEAD_BEEF -> s_pready at T+6, s_prdata=0xDEAD_BEEF.
- TIMEOUT_CYCLES=16, m_pready held 0 -> abort after 16 ACCESS cycles, timeout_pulse=1 for one cycle, s_pslverr=1, s_prdata=0, busy falls after RESP.
- psel=4'b0110 -> no downstream activity (m_psel stays 0), s_pready=1 at T+1 with s_pslverr=1.
- m_pready=1 on exactly the 16th ACCESS cycle -> normal completion, timeout_pulse stays 0, s_pslverr=m_pslverr.
- reset_n pulsed low during ACCESS -> m_psel, m_penable and busy drop to 0 asynchronously; no s_pready; next transfer after release completes normally.
